// File: rtl/apb_reg_slave.sv
// APB register-file slave: word-aligned decode into numRegs registers,
// byte-strobed writes, fixed wait-state insertion and error responses.
// Register 0 is a read-only ID constant; all contents are exported flat on regOut.
module apb_reg_slave #(
  parameter int                   dataWidth  = 32,
  parameter int                   addrWidth  = 32,
  parameter int                   numRegs    = 16,
  parameter int                   waitStates = 2,
  parameter logic [dataWidth-1:0] idValue    = 32'hA7B0_0001
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          psel,
  input  logic                          penable,
  input  logic                          pwrite,
  input  logic [addrWidth-1:0]          paddr,
  input  logic [dataWidth-1:0]          pwdata,
  input  logic [dataWidth/8-1:0]        pstrb,
  output logic [dataWidth-1:0]          prdata,
  output logic                          pready,
  output logic                          pslverr,
  output logic [numRegs*dataWidth-1:0]  regOut
);

  localparam int strbWidth = dataWidth / 8;
  localparam int idxWidth  = $clog2(numRegs);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]           state_reg, state_next;
  logic [3:0]           cnt_reg;
  logic [addrWidth-1:0] cap_addr_reg;
  logic                 cap_write_reg;
  logic [dataWidth-1:0] cap_wdata_reg;
  logic [strbWidth-1:0] cap_strb_reg;
  logic [dataWidth-1:0] prdata_reg;
  logic                 pslverr_reg;

  logic                 setup;
  logic [addrWidth-1:0] dec_addr;
  logic                 dec_write;
  logic [idxWidth-1:0]  dec_idx;
  logic                 dec_err;
  logic [dataWidth-1:0] rd_data;
  logic                 commit;

  assign setup = psel & ~penable;

  // In IDLE the setup phase is being sampled this cycle, so decode the live
  // bus; afterwards decode the copy captured at the setup edge.
  assign dec_addr  = (state_reg == IDLE) ? paddr  : cap_addr_reg;
  assign dec_write = (state_reg == IDLE) ? pwrite : cap_write_reg;
  assign dec_idx   = dec_addr[2 +: idxWidth];

  // Error decode: misaligned, bits above the index field, nonexistent index, or ID write.
  always_comb begin
    dec_err = 1'b0;
    if (dec_addr[1:0] != 2'b00)                    dec_err = 1'b1;
    if ((dec_addr >> (2 + idxWidth)) != '0)        dec_err = 1'b1;
    if (int'(dec_idx) >= numRegs)                  dec_err = 1'b1;
    if (dec_write && (dec_idx == '0))              dec_err = 1'b1;
  end

  // Read mux over the flat register image; errors and writes return zero.
  always_comb begin
    rd_data = '0;
    if (!dec_err && !dec_write) begin
      for (int i = 0; i < numRegs; i++) begin
        if (dec_idx == idxWidth'(i)) rd_data = regOut[i*dataWidth +: dataWidth];
      end
    end
  end

  // Commit only at the edge ending RESP with the master still holding a write access.
  assign commit = (state_reg == RESP) && psel && penable && pwrite && cap_write_reg && !dec_err;

  // Next-state logic; dropping psel mid-transfer aborts back to IDLE.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (setup) state_next = (waitStates == 0) ? RESP : WAIT;
      WAIT: begin
        if (!psel)                 state_next = IDLE;
        else if (cnt_reg == 4'd1)  state_next = RESP;
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register and wait-state counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      cnt_reg   <= 4'd0;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && setup)      cnt_reg <= 4'(waitStates);
      else if (state_reg == WAIT && psel)  cnt_reg <= cnt_reg - 4'd1;
    end
  end

  // Capture the request at the setup edge so later bus changes are ignored.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cap_addr_reg  <= '0;
      cap_write_reg <= 1'b0;
      cap_wdata_reg <= '0;
      cap_strb_reg  <= '0;
    end else if (state_reg == IDLE && setup) begin
      cap_addr_reg  <= paddr;
      cap_write_reg <= pwrite;
      cap_wdata_reg <= pwdata;
      cap_strb_reg  <= pstrb;
    end
  end

  // Response data is registered on entry to RESP and held at zero otherwise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prdata_reg  <= '0;
      pslverr_reg <= 1'b0;
    end else if (state_next == RESP) begin
      prdata_reg  <= rd_data;
      pslverr_reg <= dec_err;
    end else begin
      prdata_reg  <= '0;
      pslverr_reg <= 1'b0;
    end
  end

  assign pready  = (state_reg == RESP);
  assign prdata  = prdata_reg;
  assign pslverr = pslverr_reg;

  genvar gi;
  generate
    for (gi = 0; gi < numRegs; gi++) begin : g_reg
      if (gi == 0) begin : g_id
        assign regOut[0 +: dataWidth] = idValue;
      end else begin : g_rw
        logic [dataWidth-1:0] value_reg;

        // Byte-strobed register update at the commit edge.
        always_ff @(posedge clk or negedge rst) begin
          if (!rst) begin
            value_reg <= '0;
          end else if (commit && (cap_addr_reg[2 +: idxWidth] == idxWidth'(gi))) begin
            for (int b = 0; b < strbWidth; b++) begin
              if (cap_strb_reg[b]) value_reg[b*8 +: 8] <= cap_wdata_reg[b*8 +: 8];
            end
          end
        end

        assign regOut[gi*dataWidth +: dataWidth] = value_reg;
      end
    end
  endgenerate

endmodule

// File: tb/tb_apb_reg_slave.sv
// Directed bench for apb_reg_slave: instance a uses 2 wait states, instance b
// uses 0 wait states for back-to-back traffic. Expected responses are queued
// when a transfer is driven and popped when pready is seen.
module tb_apb_reg_slave;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int NR = 16;
  localparam logic [31:0] ID = 32'hA7B0_0001;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic           a_psel, a_penable, a_pwrite, a_pready, a_pslverr;
  logic [AW-1:0]  a_paddr;
  logic [DW-1:0]  a_pwdata, a_prdata;
  logic [3:0]     a_pstrb;
  logic [NR*DW-1:0] a_regout;

  logic           b_psel, b_penable, b_pwrite, b_pready, b_pslverr;
  logic [AW-1:0]  b_paddr;
  logic [DW-1:0]  b_pwdata, b_prdata;
  logic [3:0]     b_pstrb;
  logic [NR*DW-1:0] b_regout;

  apb_reg_slave #(.dataWidth(DW), .addrWidth(AW), .numRegs(NR), .waitStates(2), .idValue(ID)) u_a (
    .clk(clk), .rst(rst), .psel(a_psel), .penable(a_penable), .pwrite(a_pwrite),
    .paddr(a_paddr), .pwdata(a_pwdata), .pstrb(a_pstrb), .prdata(a_prdata),
    .pready(a_pready), .pslverr(a_pslverr), .regOut(a_regout));

  apb_reg_slave #(.dataWidth(DW), .addrWidth(AW), .numRegs(NR), .waitStates(0), .idValue(ID)) u_b (
    .clk(clk), .rst(rst), .psel(b_psel), .penable(b_penable), .pwrite(b_pwrite),
    .paddr(b_paddr), .pwdata(b_pwdata), .pstrb(b_pstrb), .prdata(b_prdata),
    .pready(b_pready), .pslverr(b_pslverr), .regOut(b_regout));

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] rg(input bit use_b, input int i);
    return use_b ? b_regout[i*DW +: DW] : a_regout[i*DW +: DW];
  endfunction

  task automatic drive_setup(input bit use_b, input logic wr, input logic [31:0] addr,
                             input logic [31:0] data, input logic [3:0] strb);
    if (!use_b) begin
      a_psel = 1; a_penable = 0; a_pwrite = wr; a_paddr = addr; a_pwdata = data; a_pstrb = strb;
    end else begin
      b_psel = 1; b_penable = 0; b_pwrite = wr; b_paddr = addr; b_pwdata = data; b_pstrb = strb;
    end
  endtask

  task automatic drive_access(input bit use_b);
    if (!use_b) a_penable = 1; else b_penable = 1;
  endtask

  task automatic bus_idle_now(input bit use_b);
    if (!use_b) begin a_psel = 0; a_penable = 0; end
    else begin b_psel = 0; b_penable = 0; end
  endtask

  task automatic bus_idle(input bit use_b);
    @(posedge clk); #1;
    bus_idle_now(use_b);
  endtask

  // One full transfer; leaves the access phase asserted so the next call is back-to-back.
  task automatic xfer(input bit use_b, input string tag, input logic wr, input logic [31:0] addr,
                      input logic [31:0] data, input logic [3:0] strb,
                      input logic [31:0] exp_rdata, input logic exp_err);
    int   cyc;
    int   ws;
    logic rdy;
    exp_t e;
    ws = use_b ? 0 : 2;
    @(posedge clk); #1;
    drive_setup(use_b, wr, addr, data, strb);
    exp_q.push_back('{rdata: exp_rdata, err: exp_err});
    @(posedge clk); #1;
    drive_access(use_b);
    @(negedge clk);
    cyc = 1;
    rdy = use_b ? b_pready : a_pready;
    while (!rdy && cyc < 20) begin
      @(negedge clk);
      cyc++;
      rdy = use_b ? b_pready : a_pready;
    end
    e = exp_q.pop_front();
    check({tag, "_latency"}, 32'(cyc), 32'(ws + 1));
    check({tag, "_pslverr"}, {31'd0, use_b ? b_pslverr : a_pslverr}, {31'd0, e.err});
    if (!wr) check({tag, "_prdata"}, use_b ? b_prdata : a_prdata, e.rdata);
    $display("xfer %s dut=%0d wr=%0d addr=%h wdata=%h strb=%h prdata=%h pslverr=%0d cycles=%0d",
             tag, use_b, wr, addr, data, strb, use_b ? b_prdata : a_prdata,
             use_b ? b_pslverr : a_pslverr, cyc);
  endtask

  initial begin
    a_psel = 0; a_penable = 0; a_pwrite = 0; a_paddr = '0; a_pwdata = '0; a_pstrb = '0;
    b_psel = 0; b_penable = 0; b_pwrite = 0; b_paddr = '0; b_pwdata = '0; b_pstrb = '0;
    rst = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_pready", {31'd0, a_pready}, 32'd0);
    check("rst_pslverr", {31'd0, a_pslverr}, 32'd0);
    check("rst_prdata", a_prdata, 32'd0);
    check("rst_reg0", rg(0, 0), ID);
    for (int i = 1; i < NR; i++) check($sformatf("rst_reg%0d", i), rg(0, i), 32'd0);
    rst = 1;

    // Reads of the ID register and basic wait-state write/read.
    xfer(0, "rd_id", 0, 32'h0, 32'h0, 4'h0, ID, 0);
    xfer(0, "wr_r1", 1, 32'h4, 32'hDEADBEEF, 4'hF, 32'h0, 0);
    xfer(0, "rd_r1", 0, 32'h4, 32'h0, 4'h0, 32'hDEADBEEF, 0);
    bus_idle(0);
    check("regout_r1", rg(0, 1), 32'hDEADBEEF);

    // Byte strobes.
    xfer(0, "wr_r2_full", 1, 32'h8, 32'h11223344, 4'hF, 32'h0, 0);
    xfer(0, "wr_r2_strb", 1, 32'h8, 32'hAABBCCDD, 4'b0101, 32'h0, 0);
    xfer(0, "rd_r2", 0, 32'h8, 32'h0, 4'h0, 32'h11BB33DD, 0);
    bus_idle(0);
    check("regout_r2", rg(0, 2), 32'h11BB33DD);

    // Error responses and the top legal register.
    xfer(0, "wr_id_err", 1, 32'h0, 32'hFFFFFFFF, 4'hF, 32'h0, 1);
    xfer(0, "rd_unaligned", 0, 32'h6, 32'h0, 4'h0, 32'h0, 1);
    xfer(0, "rd_oob", 0, 32'h40, 32'h0, 4'h0, 32'h0, 1);
    xfer(0, "wr_oob", 1, 32'h44, 32'hFFFFFFFF, 4'hF, 32'h0, 1);
    xfer(0, "rd_r15", 0, 32'h3C, 32'h0, 4'h0, 32'h0, 0);
    bus_idle(0);
    check("regout_r0_after_err", rg(0, 0), ID);
    check("regout_r15_after_oob", rg(0, 15), 32'h0);

    // Abort a write by dropping psel during WAIT.
    @(posedge clk); #1;
    drive_setup(0, 1, 32'hC, 32'h12345678, 4'hF);
    @(posedge clk); #1;
    drive_access(0);
    @(negedge clk);
    check("abort_wait_pready", {31'd0, a_pready}, 32'd0);
    @(posedge clk); #1;
    bus_idle_now(0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("abort_pready_c%0d", i), {31'd0, a_pready}, 32'd0);
    end
    check("abort_regout_r3", rg(0, 3), 32'h0);
    $display("xfer abort dut=0 addr=0000000c reg3=%h", rg(0, 3));
    xfer(0, "rd_r3_after_abort", 0, 32'hC, 32'h0, 4'h0, 32'h0, 0);
    bus_idle(0);

    // Asynchronous reset asserted during WAIT.
    @(posedge clk); #1;
    drive_setup(0, 1, 32'h4, 32'h00000055, 4'hF);
    @(posedge clk); #1;
    drive_access(0);
    @(negedge clk);
    check("prerst_r1", rg(0, 1), 32'hDEADBEEF);
    #1 rst = 0;
    #1;
    check("midrst_pready", {31'd0, a_pready}, 32'd0);
    check("midrst_pslverr", {31'd0, a_pslverr}, 32'd0);
    check("midrst_prdata", a_prdata, 32'd0);
    check("midrst_r0", rg(0, 0), ID);
    check("midrst_r1", rg(0, 1), 32'h0);
    check("midrst_r2", rg(0, 2), 32'h0);
    $display("xfer reset_in_wait dut=0 reg1=%h pready=%0d", rg(0, 1), a_pready);
    bus_idle_now(0);
    @(posedge clk); #1;
    rst = 1;

    // penable without a preceding setup phase must be ignored.
    @(posedge clk); #1;
    a_psel = 1; a_penable = 1; a_pwrite = 1; a_paddr = 32'h4; a_pwdata = 32'h0000FFFF; a_pstrb = 4'hF;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("noset_pready_c%0d", i), {31'd0, a_pready}, 32'd0);
    end
    bus_idle(0);
    check("noset_regout_r1", rg(0, 1), 32'h0);
    $display("xfer penable_only dut=0 reg1=%h", rg(0, 1));

    // Back-to-back transfers with zero wait states.
    xfer(1, "b2b_wr_r1", 1, 32'h4, 32'hCAFEF00D, 4'hF, 32'h0, 0);
    xfer(1, "b2b_rd_r1", 0, 32'h4, 32'h0, 4'h0, 32'hCAFEF00D, 0);
    xfer(1, "b2b_rd_id", 0, 32'h0, 32'h0, 4'h0, ID, 0);
    bus_idle(1);
    check("b2b_regout_r1", rg(1, 1), 32'hCAFEF00D);
    check("b2b_idle_pready", {31'd0, b_pready}, 32'd0);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
